// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap sequencer: arbitrates CLINT/external interrupts,
// drains the pipeline, writes mepc/mcause/mstatus and redirects fetch; also sequences mret.
module irq_trap_ctrl #(
   parameter int XLEN         = 32,
   parameter bit MTVEC_VEC_EN = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            timer_irq_i,
   input  logic            software_irq_i,
   input  logic            ext_irq_i,
   input  logic [XLEN-1:0] mstatus_i,
   input  logic [XLEN-1:0] mie_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            ex_valid_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic            mret_i,
   input  logic            mem_busy_i,
   output logic            hold_o,
   output logic            flush_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            csr_we_o,
   output logic [11:0]     csr_waddr_o,
   output logic [XLEN-1:0] csr_wdata_o,
   output logic [XLEN-1:0] mip_o,
   output logic [2:0]      dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DRAIN    = 3'd1,
      S_WMEPC    = 3'd2,
      S_WMCAUSE  = 3'd3,
      S_WMSTATUS = 3'd4,
      S_MRET     = 3'd5,
      S_REDIR    = 3'd6
   } state_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   state_t          state_q, state_d;
   logic [3:0]      cause_q, cause_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            hold_q, hold_d;
   logic            flush_q, flush_d;
   logic            we_q, we_d;
   logic [11:0]     waddr_q, waddr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] redir_q, redir_d;

   logic [XLEN-1:0] pend;
   logic            take;
   logic [3:0]      irq_cause;
   logic [XLEN-1:0] mcause;
   logic [XLEN-1:0] trap_mstatus;
   logic [XLEN-1:0] mret_mstatus;
   logic [XLEN-1:0] tvec_base;
   logic [XLEN-1:0] trap_target;

   always_comb begin
      mip_o     = '0;
      mip_o[11] = ext_irq_i;
      mip_o[7]  = timer_irq_i;
      mip_o[3]  = software_irq_i;
   end

   assign pend = mip_o & mie_i;
   assign take = ex_valid_i & mstatus_i[3] & (|pend);

   // Fixed priority: external, then software, then timer.
   always_comb begin
      if (pend[11])     irq_cause = 4'd11;
      else if (pend[3]) irq_cause = 4'd3;
      else              irq_cause = 4'd7;
   end

   assign mcause = {1'b1, {(XLEN-5){1'b0}}, cause_q};

   always_comb begin
      trap_mstatus        = mstatus_i;
      trap_mstatus[7]     = mstatus_i[3];
      trap_mstatus[3]     = 1'b0;
      trap_mstatus[12:11] = 2'b11;
      mret_mstatus        = mstatus_i;
      mret_mstatus[3]     = mstatus_i[7];
      mret_mstatus[7]     = 1'b1;
      mret_mstatus[12:11] = 2'b11;
   end

   // mtvec modes 2 and 3 fall back to direct.
   assign tvec_base = {mtvec_i[XLEN-1:2], 2'b00};
   always_comb begin
      if (MTVEC_VEC_EN && (mtvec_i[1:0] == 2'b01))
         trap_target = tvec_base + {{(XLEN-6){1'b0}}, cause_q, 2'b00};
      else
         trap_target = tvec_base;
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      pc_d    = pc_q;
      flush_d = 1'b0;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      redir_d = redir_q;
      case (state_q)
         S_IDLE: begin
            if (take) begin
               cause_d = irq_cause;
               pc_d    = ex_pc_i;
               state_d = S_DRAIN;
            end else if (ex_valid_i && mret_i) begin
               pc_d    = mepc_i;
               we_d    = 1'b1;
               waddr_d = CSR_MSTATUS;
               wdata_d = mret_mstatus;
               state_d = S_MRET;
            end
         end
         S_DRAIN: begin
            if (!mem_busy_i) begin
               we_d    = 1'b1;
               waddr_d = CSR_MEPC;
               wdata_d = pc_q;
               state_d = S_WMEPC;
            end
         end
         S_WMEPC: begin
            we_d    = 1'b1;
            waddr_d = CSR_MCAUSE;
            wdata_d = mcause;
            state_d = S_WMCAUSE;
         end
         S_WMCAUSE: begin
            we_d    = 1'b1;
            waddr_d = CSR_MSTATUS;
            wdata_d = trap_mstatus;
            state_d = S_WMSTATUS;
         end
         S_WMSTATUS: begin
            flush_d = 1'b1;
            redir_d = trap_target;
            state_d = S_REDIR;
         end
         S_MRET: begin
            flush_d = 1'b1;
            redir_d = pc_q;
            state_d = S_REDIR;
         end
         S_REDIR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      hold_d = (state_d != S_IDLE);
   end

   // Outputs are registered against the next state so they line up with it.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cause_q <= '0;
         pc_q    <= '0;
         hold_q  <= 1'b0;
         flush_q <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         redir_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         flush_q <= flush_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         redir_q <= redir_d;
      end
   end

   assign hold_o        = hold_q;
   assign flush_o       = flush_q;
   assign redirect_pc_o = redir_q;
   assign csr_we_o      = we_q;
   assign csr_waddr_o   = waddr_q;
   assign csr_wdata_o   = wdata_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl: trap entry, priority/vectoring, drain, mret, masking, async reset.
module tb_irq_trap_ctrl;

   localparam int XLEN = 32;

   logic            clk_i;
   logic            rst_i;
   logic            timer_irq_i, software_irq_i, ext_irq_i;
   logic [XLEN-1:0] mstatus_i, mie_i, mtvec_i, mepc_i, ex_pc_i;
   logic            ex_valid_i, mret_i, mem_busy_i;
   logic            hold_o, flush_o, csr_we_o;
   logic [XLEN-1:0] redirect_pc_o, csr_wdata_o, mip_o;
   logic [11:0]     csr_waddr_o;
   logic [2:0]      dbg_state_o;

   int tests_run = 0;
   int tests_failed = 0;

   irq_trap_ctrl #(.XLEN(XLEN), .MTVEC_VEC_EN(1'b1)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .timer_irq_i(timer_irq_i), .software_irq_i(software_irq_i), .ext_irq_i(ext_irq_i),
      .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
      .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .mret_i(mret_i), .mem_busy_i(mem_busy_i),
      .hold_o(hold_o), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
      .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
      .mip_o(mip_o), .dbg_state_o(dbg_state_o)
   );

   // clock / reset
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_irqs();
      timer_irq_i    = 1'b0;
      software_irq_i = 1'b0;
      ext_irq_i      = 1'b0;
   endtask

   // Caller arms the interrupt inputs; the next edge is the detecting edge.
   task automatic run_trap(input string tag, input int busy, input logic [XLEN-1:0] exp_pc,
                           input logic [XLEN-1:0] exp_cause, input logic [XLEN-1:0] exp_ms,
                           input logic [XLEN-1:0] exp_tgt);
      mem_busy_i = (busy > 0);
      step();
      check({tag, "_drain_hold"}, hold_o, 1);
      check({tag, "_drain_we"}, csr_we_o, 0);
      ex_valid_i = 1'b0;
      mret_i     = 1'b0;
      clear_irqs();
      for (int i = 1; i < busy; i++) begin
         step();
         check({tag, "_busy_hold"}, hold_o, 1);
         check({tag, "_busy_we"}, csr_we_o, 0);
      end
      mem_busy_i = 1'b0;
      step();
      check({tag, "_mepc_we"}, csr_we_o, 1);
      check({tag, "_mepc_addr"}, csr_waddr_o, 12'h341);
      check({tag, "_mepc_data"}, csr_wdata_o, exp_pc);
      check({tag, "_mepc_hold"}, hold_o, 1);
      step();
      check({tag, "_mcause_we"}, csr_we_o, 1);
      check({tag, "_mcause_addr"}, csr_waddr_o, 12'h342);
      check({tag, "_mcause_data"}, csr_wdata_o, exp_cause);
      step();
      check({tag, "_mstatus_we"}, csr_we_o, 1);
      check({tag, "_mstatus_addr"}, csr_waddr_o, 12'h300);
      check({tag, "_mstatus_data"}, csr_wdata_o, exp_ms);
      check({tag, "_mstatus_flush"}, flush_o, 0);
      step();
      check({tag, "_redir_flush"}, flush_o, 1);
      check({tag, "_redir_pc"}, redirect_pc_o, exp_tgt);
      check({tag, "_redir_we"}, csr_we_o, 0);
      check({tag, "_redir_hold"}, hold_o, 1);
      step();
      check({tag, "_done_flush"}, flush_o, 0);
      check({tag, "_done_hold"}, hold_o, 0);
      check({tag, "_done_state"}, dbg_state_o, 0);
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         step();
         check({tag, "_hold"}, hold_o, 0);
         check({tag, "_flush"}, flush_o, 0);
         check({tag, "_we"}, csr_we_o, 0);
      end
   endtask

   initial begin
      rst_i = 1'b0;
      clear_irqs();
      mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0; ex_pc_i = '0;
      ex_valid_i = 1'b0; mret_i = 1'b0; mem_busy_i = 1'b0;

      // reset state, mip tracks inputs during reset
      step();
      timer_irq_i = 1'b1;
      #1;
      check("rst_mip_timer", mip_o, 32'h0000_0080);
      ext_irq_i = 1'b1; software_irq_i = 1'b1;
      #1;
      check("rst_mip_all", mip_o, 32'h0000_0888);
      check("rst_hold", hold_o, 0);
      check("rst_flush", flush_o, 0);
      check("rst_we", csr_we_o, 0);
      check("rst_waddr", csr_waddr_o, 0);
      check("rst_wdata", csr_wdata_o, 0);
      check("rst_redir", redirect_pc_o, 0);
      clear_irqs();
      step();
      rst_i = 1'b1;
      step();
      check("idle_state", dbg_state_o, 0);

      // timer interrupt, direct mode, 5-cycle latency
      mtvec_i = 32'h8000_0100; mie_i = 32'h80; mstatus_i = 32'h8;
      ex_pc_i = 32'h8000_0040; ex_valid_i = 1'b1; timer_irq_i = 1'b1;
      run_trap("timer", 0, 32'h8000_0040, 32'h8000_0007, 32'h0000_1880, 32'h8000_0100);

      // all pending, vectored: external wins
      mie_i = 32'h888; mtvec_i = 32'h8000_0201; ex_pc_i = 32'h8000_0080; ex_valid_i = 1'b1;
      timer_irq_i = 1'b1; software_irq_i = 1'b1; ext_irq_i = 1'b1;
      run_trap("prio_ext", 0, 32'h8000_0080, 32'h8000_000B, 32'h0000_1880, 32'h8000_022C);

      // ext cleared: software beats timer
      ex_pc_i = 32'h8000_0084; ex_valid_i = 1'b1;
      timer_irq_i = 1'b1; software_irq_i = 1'b1;
      run_trap("prio_sw", 0, 32'h8000_0084, 32'h8000_0003, 32'h0000_1880, 32'h8000_020C);

      // mtvec mode 3 treated as direct
      mie_i = 32'h80; mtvec_i = 32'h8000_0303; ex_pc_i = 32'h8000_0090; ex_valid_i = 1'b1;
      timer_irq_i = 1'b1;
      run_trap("mode3", 0, 32'h8000_0090, 32'h8000_0007, 32'h0000_1880, 32'h8000_0300);

      // drain: mem_busy held for 3 cycles from the detecting edge
      mtvec_i = 32'h8000_0100; ex_pc_i = 32'h8000_00A0; ex_valid_i = 1'b1; timer_irq_i = 1'b1;
      run_trap("drain", 3, 32'h8000_00A0, 32'h8000_0007, 32'h0000_1880, 32'h8000_0100);

      // mret: 2-cycle latency
      mstatus_i = 32'h1880; mepc_i = 32'h8000_0044; mret_i = 1'b1; ex_valid_i = 1'b1;
      step();
      check("mret_hold", hold_o, 1);
      check("mret_we", csr_we_o, 1);
      check("mret_addr", csr_waddr_o, 12'h300);
      check("mret_data", csr_wdata_o, 32'h0000_1888);
      mret_i = 1'b0; ex_valid_i = 1'b0; mepc_i = 32'h0;
      step();
      check("mret_flush", flush_o, 1);
      check("mret_redir", redirect_pc_o, 32'h8000_0044);
      check("mret_we_off", csr_we_o, 0);
      step();
      check("mret_done_hold", hold_o, 0);
      check("mret_done_flush", flush_o, 0);

      // masking
      mstatus_i = 32'h0; mie_i = 32'h80; ex_valid_i = 1'b1; timer_irq_i = 1'b1;
      expect_quiet("mask_mie_bit", 2);
      mstatus_i = 32'h8; mie_i = 32'h0;
      expect_quiet("mask_mie_reg", 2);
      mie_i = 32'h80; ex_valid_i = 1'b0;
      expect_quiet("mask_exvalid", 2);

      // mret and timer together: interrupt wins, mepc = mret PC
      mstatus_i = 32'h8; mie_i = 32'h80; mtvec_i = 32'h8000_0100; mepc_i = 32'h0000_1234;
      ex_pc_i = 32'h8000_0060; ex_valid_i = 1'b1; mret_i = 1'b1; timer_irq_i = 1'b1;
      run_trap("race", 0, 32'h8000_0060, 32'h8000_0007, 32'h0000_1880, 32'h8000_0100);

      // async reset during WMCAUSE
      ex_pc_i = 32'h8000_00C0; ex_valid_i = 1'b1; timer_irq_i = 1'b1;
      step();
      ex_valid_i = 1'b0; clear_irqs();
      step();
      step();
      check("rstmid_in_wmcause", csr_waddr_o, 12'h342);
      #2;
      rst_i = 1'b0;
      #1;
      check("rstmid_hold", hold_o, 0);
      check("rstmid_we", csr_we_o, 0);
      check("rstmid_addr", csr_waddr_o, 0);
      check("rstmid_data", csr_wdata_o, 0);
      check("rstmid_state", dbg_state_o, 0);
      step();
      check("rstmid_held_we", csr_we_o, 0);
      rst_i = 1'b1;
      expect_quiet("rstmid_after", 4);
      check("rstmid_idle", dbg_state_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/irq_trap_ctrl.md
Name: irq_trap_ctrl

Overview:
- Machine-mode interrupt and trap sequencer on the CSR side of the core.
- Consumes the timer and software interrupt lines driven by the CLINT, plus the external interrupt line.
- Arbitrates pending and enabled interrupts, holds and drains the pipeline, then writes mepc, mcause and mstatus through the CSR write port and redirects fetch to mtvec.
- Also sequences mret (mstatus restore, jump to mepc).

Parameters:
- XLEN, 32, data/address width.
- MTVEC_VEC_EN, 1, 1 = honour mtvec vectored mode; 0 = always use direct mode.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- timer_irq_i  in  1  machine timer interrupt level, from CLINT.
- software_irq_i  in  1  machine software interrupt level, from CLINT.
- ext_irq_i  in  1  machine external interrupt level.
- mstatus_i  in  XLEN  current mstatus (MIE=bit3, MPIE=bit7, MPP=bits12:11).
- mie_i  in  XLEN  current mie (MSIE=3, MTIE=7, MEIE=11).
- mtvec_i  in  XLEN  current mtvec.
- mepc_i  in  XLEN  current mepc.
- ex_valid_i  in  1  instruction in EX is valid and next to commit.
- ex_pc_i  in  XLEN  PC of the EX instruction.
- mret_i  in  1  EX instruction is mret.
- mem_busy_i  in  1  outstanding load/store on the data bus.
- hold_o  out  1  stall all pipeline stages.
- flush_o  out  1  one-cycle flush with redirect.
- redirect_pc_o  out  XLEN  fetch target, valid while flush_o=1.
- csr_we_o  out  1  CSR write strobe.
- csr_waddr_o  out  12  CSR address (0x341 mepc, 0x342 mcause, 0x300 mstatus).
- csr_wdata_o  out  XLEN  CSR write data.
- mip_o  out  XLEN  combinational mip view: bit11=ext, bit7=timer, bit3=sw, others 0.

Behaviour:
- Reset (rst_i=0, async): state IDLE; hold_o, flush_o, csr_we_o = 0; redirect_pc_o, csr_waddr_o, csr_wdata_o, and latched cause/PC = 0. mip_o tracks its inputs even in reset.
- take = ex_valid_i & mstatus_i[3] & |(mip_o & mie_i).
- Priority: ext (cause 11) > software (3) > timer (7).
- mcause = {1'b1, 27'b0, cause[3:0]}.
- States and transitions:
  - IDLE: on take, latch cause and ex_pc_i, go to DRAIN. Else on ex_valid_i & mret_i, go to MRET. Interrupt wins over a simultaneous mret; the mret is flushed and re-executes later because mepc = its PC.
  - DRAIN: stay while mem_busy_i=1, else go to WMEPC.
  - WMEPC: csr_we_o=1, addr 0x341, data = latched PC; go to WMCAUSE.
  - WMCAUSE: addr 0x342, data = mcause; go to WMSTATUS.
  - WMSTATUS: addr 0x300, data = mstatus_i with MPIE<=MIE, MIE<=0, MPP<=2'b11; go to REDIR.
  - MRET: addr 0x300, data = mstatus_i with MIE<=MPIE, MPIE<=1, MPP<=2'b11; latch mepc_i; go to REDIR.
  - REDIR: flush_o=1, redirect_pc_o = target; go to IDLE.
- hold_o=1 in every state except IDLE. All outputs are registered/state-decoded.
- Interrupt latency from the detecting edge with mem_busy_i=0: 5 cycles (DRAIN, WMEPC, WMCAUSE, WMSTATUS, REDIR). mret latency: 2 cycles.
- Target selection:
  - Trap: base = {mtvec_i[XLEN-1:2], 2'b00}. If MTVEC_VEC_EN and mtvec_i[1:0]==1, target = base + (cause<<2); otherwise target = base.
  - mret: target = latched mepc.
  - mtvec_i[1:0] values 2 and 3 are treated as direct.
- Cause is latched at IDLE; deassertion of the IRQ line after that does not abort the sequence.
- No new take is evaluated until back in IDLE. In the REDIR cycle, mstatus_i[3] has already been cleared by the write, so there is no re-entry.
- ex_valid_i=0 blocks interrupt entry (no valid mepc).
- Reset asserted mid-sequence: immediate return to IDLE, outputs zeroed, no partial writes continue.
- csr_waddr_o and csr_wdata_o hold their last values when csr_we_o=0. Only strobe-qualified values are meaningful.

Test Plan:
- Timer IRQ: mtvec=0x8000_0100 (direct), mie=0x80, mstatus=0x8, ex_pc=0x8000_0040, timer_irq=1 -> writes mepc=0x8000_0040, mcause=0x8000_0007, mstatus=0x1880; flush with redirect 0x8000_0100 exactly 5 cycles after detect.
- Priority and vectored mode: all three IRQs pending, mie=0x888, mtvec=0x8000_0201 -> mcause=0x8000_000B, redirect 0x8000_022C. Then with ext cleared -> mcause=0x8000_0003.
- Drain: mem_busy_i held 3 cycles at detect -> hold_o=1 throughout; first csr_we_o appears one cycle after mem_busy_i falls.
- mret: mstatus=0x1880, mepc=0x8000_0044, mret_i=1, no IRQ -> mstatus write 0x1888; redirect 0x8000_0044 two cycles later.
- Masking and races: MIE=0, or mie=0, or ex_valid_i=0 -> no hold/flush. mret and timer IRQ in the same cycle -> interrupt taken with mepc = mret PC.
- Async reset asserted during WMCAUSE -> all outputs 0 immediately; the mstatus write never occurs; IDLE after release.
